// File: rtl/bus_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, auto-reload and level interrupt.
// Optional one-shot mode is enabled by defining BUS_TIMER_ONESHOT_EN.
module bus_timer #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h000013C0,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        interrupt
);

    typedef enum logic [2:0] {
        IDX_CTRL     = 3'd0,
        IDX_PRESCALE = 3'd1,
        IDX_COUNT    = 3'd2,
        IDX_COMPARE  = 3'd3,
        IDX_STATUS   = 3'd4
    } reg_idx_t;

    logic [31:0]               offset;
    logic                      valid;
    reg_idx_t                  idx;

    logic                      enable;
    logic                      auto_reload;
    logic                      irq_en;
    logic                      oneshot;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic [31:0]               count;
    logic [31:0]               compare;
    logic                      match;

    logic                      wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic                      tick;
    logic [31:0]               nxt;
    logic                      hit;
    logic                      oneshot_stop;

    // Addresses below the base wrap to large offsets and fall outside the window.
    assign offset = address - BASE_ADDRESS;
    assign valid  = (offset < 32'd5);
    assign idx    = reg_idx_t'(offset[2:0]);

    assign wr_ctrl     = write && valid && (idx == IDX_CTRL);
    assign wr_prescale = write && valid && (idx == IDX_PRESCALE);
    assign wr_count    = write && valid && (idx == IDX_COUNT);
    assign wr_compare  = write && valid && (idx == IDX_COMPARE);
    assign wr_status   = write && valid && (idx == IDX_STATUS);

    assign tick = enable && (pcnt == prescale);
    assign nxt  = count + 32'd1;
    // A COUNT write in the same cycle suppresses match evaluation.
    assign hit  = tick && !wr_count && (nxt == compare);

`ifdef BUS_TIMER_ONESHOT_EN
    assign oneshot_stop = hit && oneshot;
`else
    assign oneshot_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            enable      <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            oneshot     <= 1'b0;
            prescale    <= '0;
            pcnt        <= '0;
            count       <= '0;
            compare     <= '0;
            match       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable      <= write_data[0];
                auto_reload <= write_data[1];
                irq_en      <= write_data[2];
`ifdef BUS_TIMER_ONESHOT_EN
                oneshot     <= write_data[3];
`endif
            end else if (oneshot_stop) begin
                enable <= 1'b0;
            end

            if (wr_prescale) begin
                prescale <= write_data[PRESCALE_WIDTH-1:0];
            end

            if ((wr_ctrl && !write_data[0]) || wr_prescale || oneshot_stop) begin
                pcnt <= '0;
            end else if (enable) begin
                pcnt <= tick ? '0 : pcnt + 1'b1;
            end

            if (wr_count) begin
                count <= write_data;
            end else if (tick) begin
                count <= (hit && auto_reload) ? '0 : nxt;
            end

            if (wr_compare) begin
                compare <= write_data;
            end

            if (hit) begin
                match <= 1'b1;
            end else if (wr_status && write_data[0]) begin
                match <= 1'b0;
            end
        end
    end

    assign interrupt = match & irq_en;

    always_comb begin
        read_data = '0;
        if (read && valid) begin
            case (idx)
                IDX_CTRL:     read_data = {28'd0, oneshot, irq_en, auto_reload, enable};
                IDX_PRESCALE: read_data = 32'(prescale);
                IDX_COUNT:    read_data = count;
                IDX_COMPARE:  read_data = compare;
                IDX_STATUS:   read_data = {31'd0, match};
                default:      read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer; expected values are hand-derived.
// Define BUS_TIMER_ONESHOT_EN for both bench and RTL to exercise one-shot mode.
module tb_bus_timer;

    localparam logic [31:0] BASE       = 32'h000013C0;
    localparam logic [31:0] A_CTRL     = BASE + 32'd0;
    localparam logic [31:0] A_PRESCALE = BASE + 32'd1;
    localparam logic [31:0] A_COUNT    = BASE + 32'd2;
    localparam logic [31:0] A_COMPARE  = BASE + 32'd3;
    localparam logic [31:0] A_STATUS   = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        interrupt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] v;

    bus_timer #(
        .BASE_ADDRESS  (BASE),
        .PRESCALE_WIDTH(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called between edges; returns 1 ns after the edge that commits the write.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        address    = addr;
        write_data = data;
        write      = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] val);
        address = addr;
        read    = 1'b1;
        #1;
        val  = read_data;
        read = 1'b0;
    endtask

    task automatic cyc(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        wr(A_CTRL, 32'h0);
        wr(A_COUNT, 32'h0);
        wr(A_STATUS, 32'h1);
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; write_data = '0;

        // 1: reset
        cyc(2);
        reset = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            rd(BASE + i, v);
            check($sformatf("reset_idx%0d", i), v, 32'h0);
        end
        check("reset_irq", {31'd0, interrupt}, 32'h0);
        cyc(20);
        rd(A_COUNT, v); check("reset_static", v, 32'h0);

        // Bus decode corner cases
        wr(BASE + 32'd5, 32'hDEAD_BEEF);
        rd(BASE + 32'd5, v);  check("out_of_range_hi", v, 32'h0);
        rd(BASE - 32'd1, v);  check("out_of_range_lo", v, 32'h0);
        wr(A_COMPARE, 32'h1234);
        address = A_COMPARE; read = 1'b0; #1;
        check("read_gated", read_data, 32'h0);
        address = A_COMPARE; write_data = 32'h77; write = 1'b1; read = 1'b1; #1;
        check("rd_during_wr", read_data, 32'h1234);
        @(posedge clk); #1;
        write = 1'b0;
        check("rd_after_wr", read_data, 32'h77);
        read = 1'b0;
        wr(A_CTRL, 32'hFFFF_FFF0);
        rd(A_CTRL, v); check("ctrl_unused_bits", v, 32'h0);

        // 2: compare match with irq
        wr(A_PRESCALE, 32'h0);
        wr(A_COMPARE, 32'd5);
        wr(A_CTRL, 32'h5);               // E0
        cyc(1); rd(A_COUNT, v); check("t2_count_e1", v, 32'd1);
        cyc(3); rd(A_COUNT, v); check("t2_count_e4", v, 32'd4);
        rd(A_STATUS, v); check("t2_status_e4", v, 32'h0);
        check("t2_irq_e4", {31'd0, interrupt}, 32'h0);
        cyc(1); rd(A_COUNT, v); check("t2_count_e5", v, 32'd5);
        rd(A_STATUS, v); check("t2_status_e5", v, 32'h1);
        check("t2_irq_e5", {31'd0, interrupt}, 32'h1);
        cyc(1); rd(A_COUNT, v); check("t2_count_e6", v, 32'd6);

        // 3: auto-reload, irq disabled
        quiesce();
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'h3);               // E0
        for (int unsigned i = 0; i < 6; i++) begin
            cyc(1);
            rd(A_COUNT, v);
            check($sformatf("t3_count_e%0d", i + 1), v, (i + 1) % 3);
            if (i == 2) begin
                rd(A_STATUS, v); check("t3_status_e3", v, 32'h1);
            end
        end
        check("t3_irq", {31'd0, interrupt}, 32'h0);

        // 4: prescaler 3, restart on PRESCALE rewrite
        quiesce();
        wr(A_COMPARE, 32'hFFFF_FF00);
        wr(A_PRESCALE, 32'd3);
        wr(A_CTRL, 32'h1);               // E0
        cyc(3); rd(A_COUNT, v); check("t4_count_e3", v, 32'd0);
        cyc(1); rd(A_COUNT, v); check("t4_count_e4", v, 32'd1);
        cyc(2);                          // E6, pcnt=2
        wr(A_PRESCALE, 32'd3);           // E7, pcnt forced to 0
        rd(A_COUNT, v); check("t4_count_e7", v, 32'd1);
        cyc(3); rd(A_COUNT, v); check("t4_count_e10", v, 32'd1);
        cyc(1); rd(A_COUNT, v); check("t4_count_e11", v, 32'd2);

        // 5: wrap without flag, W1C vs. set, W1C clears irq
        quiesce();
        wr(A_PRESCALE, 32'h0);
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_COMPARE, 32'h10);
        wr(A_CTRL, 32'h5);               // E0
        cyc(1); rd(A_COUNT, v); check("t5_wrap", v, 32'h0);
        rd(A_STATUS, v); check("t5_wrap_status", v, 32'h0);
        wr(A_COUNT, 32'hE);              // E2, write beats tick
        rd(A_COUNT, v); check("t5_count_wr_wins", v, 32'hE);
        cyc(1);                          // E3: count F
        wr(A_STATUS, 32'h1);             // E4: match edge
        rd(A_COUNT, v); check("t5_count_match", v, 32'h10);
        rd(A_STATUS, v); check("t5_set_wins", v, 32'h1);
        check("t5_irq_set", {31'd0, interrupt}, 32'h1);
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, v); check("t5_w0_noeffect", v, 32'h1);
        wr(A_STATUS, 32'h1);
        rd(A_STATUS, v); check("t5_w1c", v, 32'h0);
        check("t5_irq_clr", {31'd0, interrupt}, 32'h0);

        // 6: one-shot
        quiesce();
        wr(A_COMPARE, 32'd2);
        wr(A_CTRL, 32'hD);               // E0
`ifdef BUS_TIMER_ONESHOT_EN
        rd(A_CTRL, v); check("t6_ctrl_wr", v, 32'hD);
        cyc(3);
        rd(A_CTRL, v); check("t6_ctrl_stop", v, 32'hC);
        rd(A_COUNT, v); check("t6_count_hold", v, 32'd2);
        cyc(2);
        rd(A_COUNT, v); check("t6_count_hold2", v, 32'd2);
`else
        rd(A_CTRL, v); check("t6_ctrl_wr", v, 32'h5);
        cyc(3);
        rd(A_CTRL, v); check("t6_ctrl_run", v, 32'h5);
        rd(A_COUNT, v); check("t6_count_run", v, 32'd3);
        cyc(2);
        rd(A_COUNT, v); check("t6_count_run2", v, 32'd5);
`endif
        rd(A_STATUS, v); check("t6_status", v, 32'h1);

        // Reset mid-count
        wr(A_CTRL, 32'h5);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        rd(A_COUNT, v);  check("mid_reset_count", v, 32'h0);
        rd(A_CTRL, v);   check("mid_reset_ctrl", v, 32'h0);
        rd(A_STATUS, v); check("mid_reset_status", v, 32'h0);
        rd(A_COMPARE, v); check("mid_reset_compare", v, 32'h0);
        check("mid_reset_irq", {31'd0, interrupt}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
